image_writer: RTL and testbench
===============================

IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 Parameter IMG_WIDTH, default 128, frame width in pixels.
REQ-002 Parameter IMG_HEIGHT, default 128, frame height in pixels.
REQ-003 Parameter ADDR_W, default 14, frame-buffer address width; SHALL satisfy 2**ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
REQ-004 clk  in  1  single clock, 27 MHz; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 data_in  in  8  received byte from UART receive stage.
REQ-007 data_valid  in  1  one-cycle strobe qualifying data_in.
REQ-008 image_start  in  1  one-cycle strobe: new image header accepted.
REQ-009 image_end  in  1  one-cycle strobe: end-of-image marker received.
REQ-010 chunk_complete  in  1  one-cycle strobe: 256-byte chunk finished.
REQ-011 frame_ack  in  1  level from display side: frame consumed.
REQ-012 wr_en  out  1  frame-buffer write strobe, one cycle per pixel.
REQ-013 wr_addr  out  ADDR_W  frame-buffer pixel address.
REQ-014 wr_data  out  16  RGB565 pixel.
REQ-015 frame_ready  out  1  complete frame in buffer, held until acknowledged.
REQ-016 busy  out  1  high in RECEIVE state.
REQ-017 overflow  out  1  sticky: bytes arrived after frame full.
REQ-018 short_frame  out  1  sticky: image ended before frame full.
REQ-019 pixel_count  out  ADDR_W+1  pixels written this image.
REQ-020 chunk_count  out  8  chunks seen this image, wraps 255->0.

Function
REQ-021 States SHALL be IDLE, RECEIVE, DONE.
REQ-022 IDLE: image_start -> RECEIVE; data_valid, image_end, chunk_complete ignored.
REQ-023 Entering RECEIVE SHALL clear byte phase, write address, pixel_count, chunk_count, overflow, short_frame, frame_ready.
REQ-024 RECEIVE, phase 0, data_valid: latch data_in as pixel high byte, phase -> 1, no write.
REQ-025 RECEIVE, phase 1, data_valid: next cycle wr_en=1, wr_data={high byte, data_in}, wr_addr=current address; then address and pixel_count increment, phase -> 0.
REQ-026 Latency SHALL be exactly one cycle from second-byte data_valid to wr_en.
REQ-027 When pixel_count = IMG_WIDTH*IMG_HEIGHT, further data_valid bytes SHALL be dropped, no wr_en, overflow set; state unchanged.
REQ-028 RECEIVE, image_end -> DONE; dangling high byte (phase 1) discarded; short_frame set if pixel_count < IMG_WIDTH*IMG_HEIGHT.
REQ-029 chunk_complete in RECEIVE SHALL increment chunk_count.
REQ-030 DONE: frame_ready=1; frame_ack high -> IDLE with frame_ready cleared next cycle.
REQ-031 image_start in RECEIVE or DONE SHALL restart per REQ-023 (restart wins over frame_ack).
REQ-032 Simultaneous image_start or image_end with data_valid: control strobe wins, byte dropped.
REQ-033 wr_en SHALL never assert outside RECEIVE-originated writes; address never exceeds IMG_WIDTH*IMG_HEIGHT-1.
REQ-034 pixel_count, overflow, short_frame, chunk_count SHALL hold their values through DONE and IDLE until next image_start.

Reset
REQ-035 reset SHALL force state IDLE, phase 0, and all outputs 0 (wr_en, wr_addr, wr_data, frame_ready, busy, overflow, short_frame, pixel_count, chunk_count) on the next edge.
REQ-036 reset mid-RECEIVE SHALL abort without a pending wr_en on the following cycle.

Structure
REQ-037 Shared package image_pkg SHALL hold IMG_WIDTH, IMG_HEIGHT, CHUNK_SIZE=256, protocol bytes (0x01, 0x06, 0x03, 0x16) and the state encoding.
REQ-038 One sub-module, rgb565_packer (byte pair -> 16-bit pixel with phase bit), SHALL be instantiated; remaining logic in image_writer.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2)
REQ-039 image_start, bytes 0xF8,0x00,0x07,0xE0 -> wr_en twice: addr 0 data 0xF800, addr 1 data 0x07E0; pixel_count=2.
REQ-040 image_start, 16 bytes, image_end -> 8 writes addr 0..7, frame_ready=1, short_frame=0, overflow=0; frame_ack -> frame_ready=0, IDLE.
REQ-041 image_start, 18 bytes, image_end -> 8 writes only, overflow=1, wr_addr never 8.
REQ-042 image_start, 5 bytes, image_end -> 2 writes, odd byte discarded, short_frame=1, frame_ready=1.
REQ-043 reset asserted between first and second byte of a pixel -> no wr_en, all outputs 0; new image_start writes from addr 0.
REQ-044 image_start in DONE with frame_ready=1 and frame_ack=1 same cycle -> RECEIVE, frame_ready=0, counters cleared.

Source files
------------

// File: rtl/image_pkg.sv
// Shared definitions for the image receive path: frame geometry, chunk size,
// UART protocol bytes and the writer state encoding.
package image_pkg;

  localparam int IMG_WIDTH  = 128;
  localparam int IMG_HEIGHT = 128;
  localparam int CHUNK_SIZE = 256;

  localparam logic [7:0] PROTO_SOH = 8'h01;
  localparam logic [7:0] PROTO_ACK = 8'h06;
  localparam logic [7:0] PROTO_ETX = 8'h03;
  localparam logic [7:0] PROTO_SYN = 8'h16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/rgb565_packer.sv
// Pairs incoming bytes into RGB565 pixels: the first byte of a pair is held as
// the high byte, and phase tells the caller that the current byte completes a pixel.
module rgb565_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  data_in,
  output logic        phase,
  output logic [15:0] pixel
);

  logic [7:0] high_byte;

  // A clear drops any dangling high byte so the next byte starts a fresh pixel.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase     <= 1'b0;
      high_byte <= 8'h00;
    end else if (byte_valid) begin
      phase <= ~phase;
      if (!phase) begin
        high_byte <= data_in;
      end
    end
  end

  assign pixel = {high_byte, data_in};

endmodule

// File: rtl/image_writer.sv
// Turns the received UART byte stream into RGB565 frame-buffer writes and
// tracks frame completion, overflow and short frames for the display side.
module image_writer #(
  parameter int IMG_WIDTH  = image_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = image_pkg::IMG_HEIGHT,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic              image_start,
  input  logic              image_end,
  input  logic              chunk_complete,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_ready,
  output logic              busy,
  output logic              overflow,
  output logic              short_frame,
  output logic [ADDR_W:0]   pixel_count,
  output logic [7:0]        chunk_count
);

  import image_pkg::*;

  localparam int              FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W:0] FRAME_FULL   = (ADDR_W + 1)'(FRAME_PIXELS);

  state_t      state;
  state_t      next_state;
  logic        receiving;
  logic        frame_full;
  logic        byte_accept;
  logic        packer_clear;
  logic        phase;
  logic [15:0] pixel;

  assign receiving    = (state == ST_RECEIVE);
  assign frame_full   = (pixel_count == FRAME_FULL);
  assign busy         = receiving;

  // Control strobes take priority over a byte arriving in the same cycle.
  assign byte_accept  = receiving && data_valid && !image_start && !image_end;
  assign packer_clear = image_start || (receiving && image_end);

  rgb565_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (packer_clear),
    .byte_valid (byte_accept && !frame_full),
    .data_in    (data_in),
    .phase      (phase),
    .pixel      (pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (image_start) next_state = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        if (image_start)    next_state = ST_RECEIVE;
        else if (image_end) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (image_start)    next_state = ST_RECEIVE;
        else if (frame_ack) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Write address is taken from pixel_count so it can never pass the last pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 16'h0000;
      frame_ready <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      pixel_count <= '0;
      chunk_count <= 8'h00;
    end else begin
      wr_en <= 1'b0;
      if (image_start) begin
        wr_addr     <= '0;
        frame_ready <= 1'b0;
        overflow    <= 1'b0;
        short_frame <= 1'b0;
        pixel_count <= '0;
        chunk_count <= 8'h00;
      end else if (receiving) begin
        if (image_end) begin
          frame_ready <= 1'b1;
          short_frame <= (pixel_count < FRAME_FULL);
        end else if (data_valid) begin
          if (frame_full) begin
            overflow <= 1'b1;
          end else if (phase) begin
            wr_en       <= 1'b1;
            wr_addr     <= pixel_count[ADDR_W-1:0];
            wr_data     <= pixel;
            pixel_count <= pixel_count + 1'b1;
          end
        end
        if (chunk_complete) begin
          chunk_count <= chunk_count + 8'd1;
        end
      end else if (state == ST_DONE && frame_ack) begin
        frame_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_writer.sv
// Directed self-checking bench for image_writer on a 4x2 frame.
module tb_image_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          data_valid = 1'b0;
  logic          image_start = 1'b0;
  logic          image_end = 1'b0;
  logic          chunk_complete = 1'b0;
  logic          frame_ack = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_ready;
  logic          busy;
  logic          overflow;
  logic          short_frame;
  logic [AW:0]   pixel_count;
  logic [7:0]    chunk_count;

  int tests_run = 0;
  int tests_failed = 0;

  int          wr_count = 0;
  int          bad_addr = 0;
  logic [AW-1:0] log_addr [32];
  logic [15:0]   log_data [32];

  image_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .image_start    (image_start),
    .image_end      (image_end),
    .chunk_complete (chunk_complete),
    .frame_ack      (frame_ack),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_ready    (frame_ready),
    .busy           (busy),
    .overflow       (overflow),
    .short_frame    (short_frame),
    .pixel_count    (pixel_count),
    .chunk_count    (chunk_count)
  );

  always #5 clk = ~clk;

  // Record every frame-buffer write mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_count < 32) begin
        log_addr[wr_count] = wr_addr;
        log_data[wr_count] = wr_data;
      end
      if (wr_addr > AW'(W * H - 1)) bad_addr = bad_addr + 1;
      wr_count = wr_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs; returns one time unit after the sampling edge.
  task automatic applyStimulus(input logic [7:0] b, input logic dv, input logic st,
                               input logic en, input logic ck, input logic ack);
    data_in        = b;
    data_valid     = dv;
    image_start    = st;
    image_end      = en;
    chunk_complete = ck;
    frame_ack      = ack;
    @(posedge clk);
    #1;
    data_in        = 8'h00;
    data_valid     = 1'b0;
    image_start    = 1'b0;
    image_end      = 1'b0;
    chunk_complete = 1'b0;
    frame_ack      = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic startImage();
    wr_count = 0;
    bad_addr = 0;
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic endImage();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({wr_en, wr_addr, wr_data, frame_ready, busy, overflow,
                short_frame, pixel_count, chunk_count});
  endfunction

  initial begin
    @(posedge clk);
    #1;
    reset = 1'b1;
    idleCycle();
    idleCycle();
    reset = 1'b0;
    checkOutput("reset_all_zero", allOutputs(), 64'h0);

    // Two pixels, write latency and chunk counting.
    startImage();
    checkOutput("t1_busy", 64'(busy), 64'h1);
    sendByte(8'hF8);
    checkOutput("t1_no_wr_first_byte", 64'(wr_en), 64'h0);
    sendByte(8'h00);
    checkOutput("t1_wr_latency", 64'(wr_en), 64'h1);
    checkOutput("t1_addr0_now", 64'(wr_addr), 64'h0);
    sendByte(8'h07);
    sendByte(8'hE0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_wr_count", 64'(wr_count), 64'd2);
    checkOutput("t1_addr0", 64'(log_addr[0]), 64'h0);
    checkOutput("t1_data0", 64'(log_data[0]), 64'hF800);
    checkOutput("t1_addr1", 64'(log_addr[1]), 64'h1);
    checkOutput("t1_data1", 64'(log_data[1]), 64'h07E0);
    checkOutput("t1_pixel_count", 64'(pixel_count), 64'd2);
    checkOutput("t1_chunk_count", 64'(chunk_count), 64'd2);
    endImage();
    checkOutput("t1_short_frame", 64'(short_frame), 64'h1);
    checkOutput("t1_frame_ready", 64'(frame_ready), 64'h1);

    // Exactly full frame, then acknowledge.
    startImage();
    checkOutput("t2_cleared", 64'({frame_ready, short_frame, pixel_count, chunk_count}), 64'h0);
    for (int k = 0; k < 16; k++) sendByte(8'h10 + 8'(k));
    endImage();
    idleCycle();
    checkOutput("t2_wr_count", 64'(wr_count), 64'd8);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("t2_addr%0d", j), 64'(log_addr[j]), 64'(j));
      checkOutput($sformatf("t2_data%0d", j), 64'(log_data[j]),
                  64'({8'h10 + 8'(2 * j), 8'h11 + 8'(2 * j)}));
    end
    checkOutput("t2_flags", 64'({frame_ready, short_frame, overflow, busy}), 64'b1000);
    checkOutput("t2_pixel_count", 64'(pixel_count), 64'd8);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_ack_clears_ready", 64'(frame_ready), 64'h0);
    sendByte(8'h55);
    sendByte(8'h66);
    idleCycle();
    checkOutput("t2_idle_ignores_bytes", 64'(wr_count), 64'd8);
    checkOutput("t2_idle_holds_count", 64'({busy, pixel_count}), 64'h08);

    // Overflow: two bytes beyond a full frame.
    startImage();
    for (int k = 0; k < 18; k++) sendByte(8'hA0 + 8'(k));
    endImage();
    idleCycle();
    checkOutput("t3_wr_count", 64'(wr_count), 64'd8);
    checkOutput("t3_overflow", 64'(overflow), 64'h1);
    checkOutput("t3_addr_bound", 64'(bad_addr), 64'd0);
    checkOutput("t3_last_data", 64'(log_data[7]), 64'hAEAF);
    checkOutput("t3_short_frame", 64'(short_frame), 64'h0);

    // Short frame with an odd dangling byte, then restart while acknowledging.
    startImage();
    for (int k = 0; k < 5; k++) sendByte(8'h30 + 8'(k));
    endImage();
    idleCycle();
    checkOutput("t4_wr_count", 64'(wr_count), 64'd2);
    checkOutput("t4_pixel_count", 64'(pixel_count), 64'd2);
    checkOutput("t4_flags", 64'({frame_ready, short_frame, overflow}), 64'b110);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_restart_busy", 64'(busy), 64'h1);
    checkOutput("t4_restart_cleared",
                64'({frame_ready, short_frame, overflow, pixel_count, chunk_count}), 64'h0);

    // Reset between the two bytes of a pixel.
    startImage();
    sendByte(8'hAB);
    reset = 1'b1;
    sendByte(8'hCD);
    reset = 1'b0;
    checkOutput("t5_reset_all_zero", allOutputs(), 64'h0);
    idleCycle();
    checkOutput("t5_no_pending_wr", 64'(wr_en), 64'h0);
    checkOutput("t5_no_writes", 64'(wr_count), 64'd0);
    startImage();
    sendByte(8'h12);
    sendByte(8'h34);
    idleCycle();
    checkOutput("t5_wr_count", 64'(wr_count), 64'd1);
    checkOutput("t5_addr", 64'(log_addr[0]), 64'h0);
    checkOutput("t5_data", 64'(log_data[0]), 64'h1234);

    // Control strobe beats a simultaneous byte.
    startImage();
    sendByte(8'hAA);
    applyStimulus(8'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("t6_no_write", 64'(wr_count), 64'd0);
    checkOutput("t6_state", 64'({busy, frame_ready, short_frame, pixel_count}), 64'b0110000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
